// File: rtl/alu_exec_sequencer.sv
// rtl/alu_exec_sequencer.sv - four-state issue/read/exec/writeback sequencer that owns the GPR file in front of a combinational MIPS ALU
// Optional feature macro: ALU_SEQ_OVF_TRAP_EN (suppress overflowed add/sub/addi writes and raise a sticky ovf_trap).
module alu_exec_sequencer #(
  parameter logic [31:0] REG_INIT = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic [31:0] alu_instruction,
  output logic [31:0] alu_reg_a,
  output logic [31:0] alu_reg_b,
  input  logic [31:0] alu_result,
  input  logic [2:0]  alu_flags,
  output logic        done_valid,
  output logic [31:0] done_result,
  output logic [2:0]  done_flags,
  output logic        branch_taken,
  output logic        ovf_trap,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] alu_instruction_q, alu_instruction_d;
  logic [31:0] alu_reg_a_q, alu_reg_a_d;
  logic [31:0] alu_reg_b_q, alu_reg_b_d;
  logic [31:0] done_result_q, done_result_d;
  logic [2:0]  done_flags_q, done_flags_d;
  logic [31:0] gpr_q [32];
  logic [31:0] gpr_d [32];

  logic [5:0]  opcode;
  logic [4:0]  dest;
  logic        dest_wr;
  logic        ovf_hit;
  logic        wr_en;

  // Writeback decode works on the instruction already presented to the ALU.
  assign opcode = alu_instruction_q[31:26];

  always_comb begin
    dest    = 5'd0;
    dest_wr = 1'b0;
    if (opcode == 6'h00) begin
      dest    = alu_instruction_q[15:11];
      dest_wr = 1'b1;
    end else if (opcode inside {[6'h08:6'h0E]}) begin
      dest    = alu_instruction_q[20:16];
      dest_wr = 1'b1;
    end
  end

`ifdef ALU_SEQ_OVF_TRAP_EN
  logic ovf_trap_q, ovf_trap_d;
  logic ovf_op;

  assign ovf_op  = ((opcode == 6'h00) && ((alu_instruction_q[5:0] == 6'h20) ||
                                          (alu_instruction_q[5:0] == 6'h22))) ||
                   (opcode == 6'h08);
  assign ovf_hit = ovf_op && done_flags_q[0];

  always_comb begin
    ovf_trap_d = ovf_trap_q;
    if ((state_q == WB) && ovf_hit) ovf_trap_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) ovf_trap_q <= 1'b0;
    else       ovf_trap_q <= ovf_trap_d;
  end

  assign ovf_trap = ovf_trap_q;
`else
  assign ovf_hit  = 1'b0;
  assign ovf_trap = 1'b0;
`endif

  assign wr_en = (state_q == WB) && dest_wr && (dest != 5'd0) && !ovf_hit;

  always_comb begin
    state_d           = state_q;
    instr_d           = instr_q;
    alu_instruction_d = alu_instruction_q;
    alu_reg_a_d       = alu_reg_a_q;
    alu_reg_b_d       = alu_reg_b_q;
    done_result_d     = done_result_q;
    done_flags_d      = done_flags_q;
    gpr_d             = gpr_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          instr_d = in_instr;
          state_d = READ;
        end
      end
      READ: begin
        alu_instruction_d = instr_q;
        alu_reg_a_d       = gpr_q[instr_q[25:21]];
        alu_reg_b_d       = gpr_q[instr_q[20:16]];
        state_d           = EXEC;
      end
      EXEC: begin
        done_result_d = alu_result;
        done_flags_d  = alu_flags;
        state_d       = WB;
      end
      WB: begin
        if (wr_en) gpr_d[dest] = done_result_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= IDLE;
      instr_q           <= 32'h0;
      alu_instruction_q <= 32'h0;
      alu_reg_a_q       <= 32'h0;
      alu_reg_b_q       <= 32'h0;
      done_result_q     <= 32'h0;
      done_flags_q      <= 3'h0;
      for (int i = 0; i < 32; i++) gpr_q[i] <= (i == 0) ? 32'h0 : REG_INIT;
    end else begin
      state_q           <= state_d;
      instr_q           <= instr_d;
      alu_instruction_q <= alu_instruction_d;
      alu_reg_a_q       <= alu_reg_a_d;
      alu_reg_b_q       <= alu_reg_b_d;
      done_result_q     <= done_result_d;
      done_flags_q      <= done_flags_d;
      gpr_q             <= gpr_d;
    end
  end

  assign in_ready        = (state_q == IDLE) && !reset;
  assign done_valid      = (state_q == WB);
  assign alu_instruction = alu_instruction_q;
  assign alu_reg_a       = alu_reg_a_q;
  assign alu_reg_b       = alu_reg_b_q;
  assign done_result     = done_result_q;
  assign done_flags      = done_flags_q;
  assign branch_taken    = done_valid && (((opcode == 6'h04) && done_flags_q[2]) ||
                                          ((opcode == 6'h05) && !done_flags_q[2]));
  assign dbg_data        = gpr_q[dbg_addr];

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// tb/tb_alu_exec_sequencer.sv - scoreboard bench for alu_exec_sequencer with a behavioural ALU stand-in and GPR reference model
module tb_alu_exec_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = 32'h0;
  logic [31:0] alu_instruction, alu_reg_a, alu_reg_b;
  logic [31:0] alu_result;
  logic [2:0]  alu_flags;
  logic        done_valid;
  logic [31:0] done_result;
  logic [2:0]  done_flags;
  logic        branch_taken;
  logic        ovf_trap;
  logic [4:0]  dbg_addr = 5'd0;
  logic [31:0] dbg_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  flg;
    logic        br;
    int          hs;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] model_gpr [32];
  logic        model_ovf;

  alu_exec_sequencer #(.REG_INIT(32'h0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .alu_instruction(alu_instruction), .alu_reg_a(alu_reg_a), .alu_reg_b(alu_reg_b),
    .alu_result(alu_result), .alu_flags(alu_flags), .done_valid(done_valid),
    .done_result(done_result), .done_flags(done_flags), .branch_taken(branch_taken),
    .ovf_trap(ovf_trap), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // MIPS ALU behaviour: returns {zero, negative, overflow, result}.
  function automatic logic [34:0] alu_fn(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        v;
    logic [31:0] imm_s;
    logic [31:0] imm_z;
    imm_s = {{16{ins[15]}}, ins[15:0]};
    imm_z = {16'h0, ins[15:0]};
    r = 32'h0;
    v = 1'b0;
    case (ins[31:26])
      6'h00: case (ins[5:0])
        6'h20: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
        6'h21: r = a + b;
        6'h22: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
        6'h23: r = a - b;
        6'h24: r = a & b;
        6'h25: r = a | b;
        6'h26: r = a ^ b;
        6'h27: r = ~(a | b);
        6'h2A: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        6'h00: r = b << ins[10:6];
        6'h02: r = b >> ins[10:6];
        default: r = 32'h0;
      endcase
      6'h08: begin r = a + imm_s; v = (a[31] == imm_s[31]) && (r[31] != a[31]); end
      6'h09: r = a + imm_s;
      6'h0A: r = ($signed(a) < $signed(imm_s)) ? 32'd1 : 32'd0;
      6'h0B: r = (a < imm_s) ? 32'd1 : 32'd0;
      6'h0C: r = a & imm_z;
      6'h0D: r = a | imm_z;
      6'h0E: r = a ^ imm_z;
      6'h04, 6'h05: r = a - b;
      6'h23, 6'h2B: r = a + imm_s;
      default: r = 32'h0;
    endcase
    return {(r == 32'h0), r[31], v, r};
  endfunction

  always_comb {alu_flags, alu_result} = alu_fn(alu_instruction, alu_reg_a, alu_reg_b);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model_gpr[i] = 32'h0;
    model_ovf = 1'b0;
    expq.delete();
  endtask

  // Architectural effect of one instruction, straight from the destination rules.
  task automatic model_issue(input logic [31:0] ins, input int hs);
    logic [34:0] o;
    logic [5:0]  op;
    logic [4:0]  d;
    logic        wr;
    exp_t        e;
    op = ins[31:26];
    o  = alu_fn(ins, model_gpr[ins[25:21]], model_gpr[ins[20:16]]);
    e.res = o[31:0];
    e.flg = o[34:32];
    e.br  = (op == 6'h04) ? o[34] : (op == 6'h05) ? !o[34] : 1'b0;
    e.hs  = hs;
    wr = 1'b0;
    d  = 5'd0;
    if (op == 6'h00) begin wr = 1'b1; d = ins[15:11]; end
    else if (op >= 6'h08 && op <= 6'h0E) begin wr = 1'b1; d = ins[20:16]; end
`ifdef ALU_SEQ_OVF_TRAP_EN
    if (o[32] && ((op == 6'h00 && (ins[5:0] == 6'h20 || ins[5:0] == 6'h22)) || op == 6'h08)) begin
      wr = 1'b0;
      model_ovf = 1'b1;
    end
`endif
    if (wr && d != 5'd0) model_gpr[d] = o[31:0];
    expq.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done_valid === 1'b1) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 expected=0");
      end else begin
        e = expq.pop_front();
        chk("done_result", done_result, e.res);
        chk("done_flags", {29'h0, done_flags}, {29'h0, e.flg});
        chk("branch_taken", {31'h0, branch_taken}, {31'h0, e.br});
        chk("done_latency", cyc - e.hs, 32'd3);
      end
    end
  end

  task automatic issue(input logic [31:0] ins, input bit expect_done);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 40) begin @(negedge clk); n++; end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout actual=in_ready_low expected=in_ready_high");
      return;
    end
    in_valid = 1'b1;
    in_instr = ins;
    if (expect_done) model_issue(ins, cyc);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic run(input logic [31:0] ins);
    int n;
    issue(ins, 1'b1);
    n = 0;
    @(negedge clk);
    while ((expq.size() != 0 || !in_ready) && n < 40) begin @(negedge clk); n++; end
    chk("drain", expq.size(), 32'd0);
    chk("ovf_trap", {31'h0, ovf_trap}, {31'h0, model_ovf});
  endtask

  task automatic dbg_sweep();
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1 chk($sformatf("gpr%0d", i), dbg_data, model_gpr[i]);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rs, rt, rd;
    case ($urandom_range(0, 11))
      0: op = 6'h00;  1: op = 6'h08;  2: op = 6'h09;  3: op = 6'h0A;
      4: op = 6'h0C;  5: op = 6'h0D;  6: op = 6'h0E;  7: op = 6'h04;
      8: op = 6'h05;  9: op = 6'h23;  10: op = 6'h2B; default: op = 6'h3F;
    endcase
    case ($urandom_range(0, 11))
      0: fn = 6'h20;  1: fn = 6'h21;  2: fn = 6'h22;  3: fn = 6'h23;
      4: fn = 6'h24;  5: fn = 6'h25;  6: fn = 6'h26;  7: fn = 6'h27;
      8: fn = 6'h2A;  9: fn = 6'h00;  10: fn = 6'h02; default: fn = 6'h3F;
    endcase
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7));
    if (op == 6'h00) return {op, rs, rt, rd, 5'($urandom_range(0, 31)), fn};
    return {op, rs, rt, 16'($urandom)};
  endfunction

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
    chk("rst_done_valid", {31'h0, done_valid}, 32'h0);
    chk("rst_done_result", done_result, 32'h0);
    chk("rst_done_flags", {29'h0, done_flags}, 32'h0);
    chk("rst_alu_instruction", alu_instruction, 32'h0);
    chk("rst_alu_reg_a", alu_reg_a, 32'h0);
    chk("rst_alu_reg_b", alu_reg_b, 32'h0);
    chk("rst_branch_taken", {31'h0, branch_taken}, 32'h0);
    chk("rst_ovf_trap", {31'h0, ovf_trap}, 32'h0);
    reset = 1'b0;
    #1 chk("in_ready_after_reset", {31'h0, in_ready}, 32'h1);
    dbg_sweep();

    run(32'h20010005);
    run(32'h00211020);
    chk("gpr1_eq5", model_gpr[1], 32'd5);
    chk("gpr2_eq10", model_gpr[2], 32'd10);
    run(32'h10210000);
    run(32'h14210000);
    run(32'h20000007);
    dbg_sweep();

    run(32'h2003FFFF);
    run(32'h00031842);
    run(32'h00632020);
    run(32'h20050001);
    dbg_sweep();

    for (int k = 0; k < 60; k++) run(rand_instr());
    dbg_sweep();

    issue(32'h20010005, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("in_ready_during_reset", {31'h0, in_ready}, 32'h0);
    model_reset();
    reset = 1'b0;
    #1 chk("in_ready_after_abort", {31'h0, in_ready}, 32'h1);
    chk("ovf_trap_after_abort", {31'h0, ovf_trap}, 32'h0);
    repeat (6) @(negedge clk);
    dbg_sweep();
    run(32'h20010005);
    dbg_addr = 5'd1;
    #1 chk("gpr1_post_abort", dbg_data, 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_sequencer.md
# alu_exec_sequencer

Multi-cycle issue/writeback sequencer that drives the combinational MIPS ALU from the core side. It accepts one 32-bit instruction at a time over a valid/ready handshake and reads rs/rt from an internal 32x32 register file. It presents instruction and operands to the ALU, captures `result`/`flags`, writes back to the GPR file, and reports completion, branch outcome and overflow. It sits between the instruction source and the ALU and owns the architectural register state.

## Interface
Parameters:
- `REG_INIT`, default 32'h0: reset value of GPR 1..31. GPR 0 is always 0.

Ports:
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-high
- `in_valid`  in  1  instruction offered
- `in_ready`  out  1  sequencer can accept
- `in_instr`  in  32  MIPS instruction word
- `alu_instruction`  out  32  instruction presented to ALU
- `alu_reg_a`  out  32  GPR[rs]
- `alu_reg_b`  out  32  GPR[rt]
- `alu_result`  in  32  ALU result
- `alu_flags`  in  3  ALU flags {zero, negative, overflow}
- `done_valid`  out  1  one-cycle completion pulse
- `done_result`  out  32  captured ALU result
- `done_flags`  out  3  captured ALU flags
- `branch_taken`  out  1  beq/bne outcome, qualified by `done_valid`
- `ovf_trap`  out  1  sticky overflow trap
- `dbg_addr`  in  5  debug GPR index
- `dbg_data`  out  32  combinational GPR[dbg_addr]

## Operation
- FSM states: IDLE, READ, EXEC, WB.
  - IDLE: `in_ready`=1. On `in_valid`, latch `in_instr` and go to READ.
  - READ: register `alu_instruction`, `alu_reg_a`=GPR[instr[25:21]], `alu_reg_b`=GPR[instr[20:16]]. Go to EXEC.
  - EXEC: ALU settles. At the closing edge, capture `alu_result`/`alu_flags` and go to WB.
  - WB: perform the GPR write, pulse `done_valid`, go to IDLE.
- `in_ready` is 1 only in IDLE. `in_valid` is ignored elsewhere.
- Destination rules:
  - opcode 0x00: write rd (instr[15:11]).
  - opcodes 0x08–0x0E: write rt (instr[20:16]).
  - beq (0x04), bne (0x05), lw (0x23), sw (0x2B): no write. For lw/sw, `done_result` carries the computed address.
  - Any other opcode: no write; `done_valid` still pulses with the captured ALU outputs.
- A destination index of 0 is never written. `dbg_data` for index 0 is always 0.
- `branch_taken`:
  - beq: `done_flags[2]`.
  - bne: `~done_flags[2]`.
  - All other cycles and opcodes: 0.
- `done_result`, `done_flags` and `alu_*` hold their last values until overwritten.

## Timing
- Handshake accepted at edge N (IDLE, `in_valid`=1). READ occupies cycle N+1, EXEC N+2, and WB N+3 with `done_valid`=1.
- `in_ready` returns to 1 in cycle N+4. Throughput is one instruction per 4 cycles.
- The GPR write occurs at the WB closing edge. `dbg_data` shows the new value from cycle N+4.
- Reset values:
  - state IDLE
  - `in_ready`=1 in the first cycle after reset deassertion (0 while `reset` is high)
  - all other outputs 0
  - GPR0=0, GPR1..31=`REG_INIT`
  - `ovf_trap`=0
- Reset in any state abandons the instruction: no GPR write, no `done_valid`.
- Reset in the same cycle as a handshake: the handshake is dropped.
- rs==rt and rs==rd are legal. Operands are the pre-write values, because reads and writes never overlap.

## Configuration
Macro `ALU_SEQ_OVF_TRAP_EN`:
- Defined: when the captured `done_flags[0]`=1 for add (funct 0x20), sub (funct 0x22) or addi (0x08):
  - the GPR write is suppressed;
  - `ovf_trap` is set and stays 1 until `reset`;
  - `done_valid` still pulses.
- Undefined: the overflowed result is written normally and `ovf_trap` is tied to 0.

## Test plan
- Reset, then sweep `dbg_addr` 0..31 -> all reads 0. `in_ready`=1 in the cycle after reset.
- Issue 0x20010005 (addi $1,$0,5), then 0x00211020 (add $2,$1,$1) -> GPR1=5, GPR2=10. Each `done_valid` arrives exactly 3 cycles after its handshake.
- After the previous step:
  - 0x10210000 (beq $1,$1) -> `branch_taken`=1, `done_flags[2]`=1.
  - 0x14210000 (bne $1,$1) -> `branch_taken`=0.
  - No GPR changes.
- 0x20000007 (addi $0,$0,7) -> GPR0 reads 0. `done_result`=7.
- `REG_INIT`=32'h7FFFFFFF, issue 0x00632020 (add $4,$3,$3):
  - With the macro: GPR4 stays 0x7FFFFFFF and `ovf_trap`=1, still 1 after a later addi.
  - Without the macro: GPR4=0xFFFFFFFE and `ovf_trap`=0.
- Issue 0x20010005 and assert `reset` during EXEC -> no `done_valid`, GPR1=0, `in_ready`=1 in the first cycle after reset deassertion.
